aig_truth_table_sweeper: RTL and testbench

AIG_TRUTH_TABLE_SWEEPER -- requirements
Module: aig_truth_table_sweeper

---
 rtl/aig_truth_table_sweeper.sv | 151 +++++++++++++++
 tb/tb_aig_truth_table_sweeper.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aig_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// aig_truth_table_sweeper
//   Drives all 16 input vectors into a 4-input combinational AIG, captures z
//   per vector and compares the captured table against a golden truth table.
// Revision: 1.0
// ============================================================================
module aig_truth_table_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] expected_i,
    input  logic        z_i,
    output logic        x1_o,
    output logic        x2_o,
    output logic        x3_o,
    output logic        x4_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] truth_o,
    output logic [4:0]  mismatch_cnt_o,
    output logic        err_valid_o,
    output logic [3:0]  first_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [15:0] exp_q,   exp_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        errv_q,  errv_d;
    logic [3:0]  ferr_q,  ferr_d;
    logic [3:0]  idx_q,   idx_d;
    logic [3:0]  hold_q,  hold_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // idx_q doubles as the driven vector; it is forced to zero outside a sweep
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        truth_d = truth_q;
        cnt_d   = cnt_q;
        errv_d  = errv_q;
        ferr_d  = ferr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = ST_HOLD;
                    exp_d   = expected_i;
                    truth_d = 16'd0;
                    cnt_d   = 5'd0;
                    errv_d  = 1'b0;
                    ferr_d  = 4'd0;
                    idx_d   = 4'd0;
                    hold_d  = SETTLE_C;
                    busy_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = 4'd0;
                end else if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else begin
                    truth_d[idx_q] = z_i;
                    if (z_i != exp_q[idx_q]) begin
                        cnt_d = cnt_q + 5'd1;
                        if (!errv_q) begin
                            errv_d = 1'b1;
                            ferr_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        hold_d = SETTLE_C;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= 16'd0;
            truth_q <= 16'd0;
            cnt_q   <= 5'd0;
            errv_q  <= 1'b0;
            ferr_q  <= 4'd0;
            idx_q   <= 4'd0;
            hold_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            truth_q <= truth_d;
            cnt_q   <= cnt_d;
            errv_q  <= errv_d;
            ferr_q  <= ferr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x1_o           = idx_q[3];
    assign x2_o           = idx_q[2];
    assign x3_o           = idx_q[1];
    assign x4_o           = idx_q[0];
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign truth_o        = truth_q;
    assign mismatch_cnt_o = cnt_q;
    assign err_valid_o    = errv_q;
    assign first_err_o    = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_aig_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// tb_aig_truth_table_sweeper
//   Directed bench: three sweepers (SETTLE=0,1,2) each driving a stub AIG.
// Revision: 1.0
// ============================================================================
module tb_aig_truth_table_sweeper;

    localparam int ST [3] = '{0, 1, 2};

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  abort;
    logic [2:0]  z;
    logic [2:0]  x1, x2, x3, x4;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  errv;
    logic [15:0] expected [3];
    logic [15:0] truth    [3];
    logic [4:0]  cnt      [3];
    logic [3:0]  ferr     [3];
    logic [3:0]  vec      [3];

    int n_chk = 0;
    int n_err = 0;

    // Stubs: inst0 z=0, inst1 z=x4, inst2 z=x1&x2
    assign z[0] = 1'b0;
    assign z[1] = x4[1];
    assign z[2] = x1[2] & x2[2];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign vec[g] = {x1[g], x2[g], x3[g], x4[g]};
        aig_truth_table_sweeper #(.SETTLE(ST[g])) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start_i        (start[g]),
            .abort_i        (abort[g]),
            .expected_i     (expected[g]),
            .z_i            (z[g]),
            .x1_o           (x1[g]),
            .x2_o           (x2[g]),
            .x3_o           (x3[g]),
            .x4_o           (x4[g]),
            .busy_o         (busy[g]),
            .done_o         (done[g]),
            .truth_o        (truth[g]),
            .mismatch_cnt_o (cnt[g]),
            .err_valid_o    (errv[g]),
            .first_err_o    (ferr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance k; checks latency, vector order/hold, done width
    task automatic sweep(input int k, input logic [15:0] exp, input int repulse, input string tag);
        int cyc;
        int bad;
        int per;
        per = ST[k] + 1;
        bad = 0;
        expected[k] = exp;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        expected[k] = ~exp;
        cyc = 0;
        if (vec[k] !== 4'd0 || busy[k] !== 1'b1) bad++;
        while (!done[k] && cyc < 200) begin
            start[k] = (cyc == repulse);
            @(posedge clk); #1;
            start[k] = 1'b0;
            cyc++;
            if (!done[k] && (vec[k] !== 4'(cyc / per) || busy[k] !== 1'b1)) bad++;
        end
        chk({tag, " latency"}, cyc, 16 * per);
        chk({tag, " vector seq"}, bad, 0);
        chk({tag, " busy/x at done"}, {busy[k], vec[k]}, 0);
        @(posedge clk); #1;
        chk({tag, " done width"}, done[k], 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = '0;
        abort = '0;
        for (int k = 0; k < 3; k++) expected[k] = 16'h0;

        repeat (2) @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset busy/done/errv", {busy[k], done[k], errv[k]}, 0);
            chk("reset truth", truth[k], 0);
            chk("reset cnt/ferr/x", {cnt[k], ferr[k], vec[k]}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Matching golden table
        sweep(1, 16'hAAAA, -1, "s1 match");
        chk("s1 match truth", truth[1], 16'hAAAA);
        chk("s1 match cnt", cnt[1], 0);
        chk("s1 match errv", errv[1], 0);

        // Single mismatch at vector 0
        sweep(1, 16'hAAAB, -1, "s1 one-err");
        chk("s1 one-err truth", truth[1], 16'hAAAA);
        chk("s1 one-err cnt", cnt[1], 1);
        chk("s1 one-err errv", errv[1], 1);
        chk("s1 one-err ferr", ferr[1], 0);

        // Every vector mismatches, no settle cycles
        sweep(0, 16'hFFFF, -1, "s0 all-err");
        chk("s0 all-err truth", truth[0], 16'h0000);
        chk("s0 all-err cnt", cnt[0], 16);
        chk("s0 all-err errv", errv[0], 1);
        chk("s0 all-err ferr", ferr[0], 0);

        // SETTLE=2 with start re-pulsed mid-sweep
        sweep(2, 16'hF000, 10, "s2 and");
        chk("s2 and truth", truth[2], 16'hF000);
        chk("s2 and cnt", cnt[2], 0);
        chk("s2 and errv", errv[2], 0);

        // Abort while vector 5 is driven
        expected[1] = 16'h0000;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("abort at vec5", vec[1], 5);
        abort[1] = 1'b1;
        @(posedge clk); #1;
        abort[1] = 1'b0;
        chk("abort busy/x", {busy[1], done[1], vec[1]}, 0);
        chk("abort truth", truth[1], 16'h000A);
        chk("abort cnt", cnt[1], 2);
        chk("abort errv", errv[1], 1);
        chk("abort ferr", ferr[1], 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done[1] || busy[1]) seen = 1;
        end
        chk("abort no done", seen, 0);
        chk("abort truth held", truth[1], 16'h000A);

        // Abort beats start in IDLE
        start[1] = 1'b1;
        abort[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        abort[1] = 1'b0;
        chk("start+abort busy", busy[1], 0);
        chk("start+abort truth held", truth[1], 16'h000A);

        // Asynchronous reset while vector 9 is driven
        expected[1] = 16'hAAAA;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (18) @(posedge clk); #1;
        chk("pre-reset vec9", vec[1], 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy/done/errv", {busy[1], done[1], errv[1]}, 0);
        chk("async rst truth", truth[1], 0);
        chk("async rst cnt/ferr/x", {cnt[1], ferr[1], vec[1]}, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done[1] || busy[1]) seen = 1;
        end
        chk("post-reset no done", seen, 0);

        sweep(1, 16'hAAAA, -1, "post-reset");
        chk("post-reset truth", truth[1], 16'hAAAA);
        chk("post-reset cnt", cnt[1], 0);
        chk("post-reset errv", errv[1], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
